// File: rtl/fsm_master_if.sv
// Request/response bundle between a user block and the fsm_master I2C engine.
// The bidirectional sda pin stays a plain module port so tristate resolution happens at the pad level.
interface fsm_master_if #(
    parameter int ADDR_LEN = 7,
    parameter int DATA_LEN = 8
);
    logic                start;
    logic [ADDR_LEN-1:0] add_reg;
    logic                R_W;
    logic [DATA_LEN-1:0] data_1;
    logic [DATA_LEN-1:0] data_2;
    logic                scl;
    logic                free;
    logic                nack;
    logic [DATA_LEN-1:0] rd_data_1;
    logic [DATA_LEN-1:0] rd_data_2;

    modport master (
        input  start, add_reg, R_W, data_1, data_2,
        output scl, free, nack, rd_data_1, rd_data_2
    );

    modport slave (
        output start, add_reg, R_W, data_1, data_2,
        input  scl, free, nack, rd_data_1, rd_data_2
    );
endinterface

// File: rtl/fsm_master.sv
// Two-byte I2C master: START, address + R/W, two data bytes with acknowledge slots, STOP.
// Every bit slot is FREQ_DIFF clk cycles; all pin outputs come straight from registers.
module fsm_master #(
    parameter int FREQ_DIFF = 4,
    parameter int ADDR_LEN  = 7,
    parameter int DATA_LEN  = 8
) (
    input  logic         clk,
    input  logic         rst,
    fsm_master_if.master bus,
    inout  wire          sda
);
    localparam int PW  = $clog2(FREQ_DIFF);
    localparam int TXW = (ADDR_LEN + 1 > DATA_LEN) ? ADDR_LEN + 1 : DATA_LEN;
    localparam int CW  = $clog2(TXW + 1);

    localparam logic [PW-1:0] P_LAST = PW'(FREQ_DIFF - 1);
    localparam logic [PW-1:0] P_QTR  = PW'(FREQ_DIFF / 4);
    localparam logic [PW-1:0] P_HALF = PW'(FREQ_DIFF / 2);
    localparam logic [PW-1:0] P_TQTR = PW'((3 * FREQ_DIFF) / 4);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_LEN);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, DATA1, ACK_1, DATA2, ACK_2, STOP
    } state_t;

    state_t              state_reg, state_next;
    logic [PW-1:0]       phase_reg, phase_next;
    logic [CW-1:0]       bit_reg, bit_next;
    logic [TXW-1:0]      tx_reg, tx_next;

    logic [ADDR_LEN-1:0] addr_lat_reg;
    logic                rw_lat_reg;
    logic [DATA_LEN-1:0] data1_lat_reg;
    logic [DATA_LEN-1:0] data2_lat_reg;

    logic                scl_reg, scl_next;
    logic                sda_out_reg, sda_out_next;
    logic                sda_oe_reg, sda_oe_next;
    logic                free_reg;
    logic                nack_reg;
    logic [DATA_LEN-1:0] rd1_reg;
    logic [DATA_LEN-1:0] rd2_reg;

    logic                launch;
    logic                slot_end;
    logic                sample_pt;
    logic                sda_low;
    logic                ack_fail;
    logic [TXW-1:0]      addr_frame;
    logic [TXW-1:0]      byte1_frame;
    logic [TXW-1:0]      byte2_frame;

    assign sda = sda_oe_reg ? sda_out_reg : 1'bz;

    assign bus.scl       = scl_reg;
    assign bus.free      = free_reg;
    assign bus.nack      = nack_reg;
    assign bus.rd_data_1 = rd1_reg;
    assign bus.rd_data_2 = rd2_reg;

    assign launch    = (state_reg == IDLE) && bus.start;
    assign slot_end  = (phase_reg == P_LAST);
    assign sample_pt = (phase_reg == P_TQTR);
    assign sda_low   = (sda == 1'b0);
    // With FREQ_DIFF = 4 the sample point is also the slot's last cycle, so the live pin is folded in.
    assign ack_fail  = nack_reg | (sample_pt & ~sda_low);

    // Outgoing fields are left-aligned so the bit on the wire is always the MSB of tx.
    always_comb begin
        addr_frame  = '0;
        byte1_frame = '0;
        byte2_frame = '0;
        addr_frame[TXW-1 -: ADDR_LEN+1] = {addr_lat_reg, rw_lat_reg};
        byte1_frame[TXW-1 -: DATA_LEN]  = data1_lat_reg;
        byte2_frame[TXW-1 -: DATA_LEN]  = data2_lat_reg;
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        bit_next   = bit_reg;
        tx_next    = tx_reg;
        if (state_reg == IDLE) begin
            phase_next = '0;
            bit_next   = '0;
            if (bus.start) begin
                state_next = START;
            end
        end else begin
            phase_next = slot_end ? '0 : phase_reg + 1'b1;
            if (slot_end) begin
                bit_next = bit_reg + 1'b1;
                tx_next  = tx_reg << 1;
                case (state_reg)
                    START: begin
                        state_next = ADDR;
                        bit_next   = '0;
                        tx_next    = addr_frame;
                    end
                    ADDR: begin
                        if (bit_reg == ADDR_LAST) begin
                            state_next = ACK_A;
                            bit_next   = '0;
                        end
                    end
                    ACK_A: begin
                        bit_next = '0;
                        if (ack_fail) begin
                            state_next = STOP;
                        end else begin
                            state_next = DATA1;
                            tx_next    = byte1_frame;
                        end
                    end
                    DATA1: begin
                        if (bit_reg == DATA_LAST) begin
                            state_next = ACK_1;
                            bit_next   = '0;
                        end
                    end
                    ACK_1: begin
                        bit_next = '0;
                        if (!rw_lat_reg && ack_fail) begin
                            state_next = STOP;
                        end else begin
                            state_next = DATA2;
                            tx_next    = byte2_frame;
                        end
                    end
                    DATA2: begin
                        if (bit_reg == DATA_LAST) begin
                            state_next = ACK_2;
                            bit_next   = '0;
                        end
                    end
                    ACK_2:   state_next = STOP;
                    STOP:    state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Pin values for the upcoming cycle; ownership and data only move at the quarter point of a slot.
    always_comb begin
        scl_next     = (phase_next >= P_HALF);
        sda_out_next = sda_out_reg;
        sda_oe_next  = sda_oe_reg;
        case (state_next)
            IDLE: begin
                scl_next     = 1'b1;
                sda_out_next = 1'b1;
                sda_oe_next  = 1'b1;
            end
            START: begin
                scl_next     = 1'b1;
                sda_out_next = (phase_next < P_HALF);
                sda_oe_next  = 1'b1;
            end
            ADDR: begin
                if (phase_next == P_QTR) begin
                    sda_oe_next  = 1'b1;
                    sda_out_next = tx_next[TXW-1];
                end
            end
            ACK_A: begin
                if (phase_next == P_QTR) begin
                    sda_oe_next = 1'b0;
                end
            end
            DATA1, DATA2: begin
                if (phase_next == P_QTR) begin
                    sda_oe_next  = ~rw_lat_reg;
                    sda_out_next = tx_next[TXW-1];
                end
            end
            ACK_1: begin
                if (phase_next == P_QTR) begin
                    sda_oe_next  = rw_lat_reg;
                    sda_out_next = 1'b0;
                end
            end
            ACK_2: begin
                if (phase_next == P_QTR) begin
                    sda_oe_next  = rw_lat_reg;
                    sda_out_next = 1'b1;
                end
            end
            STOP: begin
                sda_oe_next  = 1'b1;
                sda_out_next = (phase_next >= P_TQTR);
            end
            default: begin
                scl_next     = 1'b1;
                sda_out_next = 1'b1;
                sda_oe_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            bit_reg       <= '0;
            tx_reg        <= '0;
            addr_lat_reg  <= '0;
            rw_lat_reg    <= 1'b0;
            data1_lat_reg <= '0;
            data2_lat_reg <= '0;
            scl_reg       <= 1'b1;
            sda_out_reg   <= 1'b1;
            sda_oe_reg    <= 1'b1;
            free_reg      <= 1'b1;
            nack_reg      <= 1'b0;
            rd1_reg       <= '0;
            rd2_reg       <= '0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            bit_reg     <= bit_next;
            tx_reg      <= tx_next;
            scl_reg     <= scl_next;
            sda_out_reg <= sda_out_next;
            sda_oe_reg  <= sda_oe_next;
            free_reg    <= (state_next == IDLE);
            if (launch) begin
                addr_lat_reg  <= bus.add_reg;
                rw_lat_reg    <= bus.R_W;
                data1_lat_reg <= bus.data_1;
                data2_lat_reg <= bus.data_2;
                nack_reg      <= 1'b0;
            end else if (sample_pt) begin
                case (state_reg)
                    ACK_A: begin
                        if (!sda_low) nack_reg <= 1'b1;
                    end
                    ACK_1, ACK_2: begin
                        if (!rw_lat_reg && !sda_low) nack_reg <= 1'b1;
                    end
                    DATA1: begin
                        if (rw_lat_reg) rd1_reg <= {rd1_reg[DATA_LEN-2:0], ~sda_low};
                    end
                    DATA2: begin
                        if (rw_lat_reg) rd2_reg <= {rd2_reg[DATA_LEN-2:0], ~sda_low};
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fsm_master.sv
// Bench for fsm_master: each transaction is expanded into a list of bit slots from the protocol
// rules, and the pins, free timing, nack and read bytes are compared against that list.
module tb_fsm_master;
    localparam int FD   = 4;
    localparam int QTR  = FD / 4;
    localparam int HALF = FD / 2;
    localparam int TQTR = (3 * FD) / 4;
    localparam int K_START = 0;
    localparam int K_MBIT  = 1;
    localparam int K_SBIT  = 2;
    localparam int K_STOP  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sl_oe = 1'b0;
    logic sl_val = 1'b1;
    wire  sda;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn = 0;
    logic [7:0] exp_rd1 = 8'h00;
    logic [7:0] exp_rd2 = 8'h00;
    logic       exp_nack = 1'b0;

    fsm_master_if #(.ADDR_LEN(7), .DATA_LEN(8)) bus ();

    fsm_master #(.FREQ_DIFF(FD), .ADDR_LEN(7), .DATA_LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .sda (sda)
    );

    assign sda = sl_oe ? sl_val : 1'bz;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_done_state();
        check_val("nack", 32'(bus.nack), 32'(exp_nack));
        check_val("rd_data_1", 32'(bus.rd_data_1), 32'(exp_rd1));
        check_val("rd_data_2", 32'(bus.rd_data_2), 32'(exp_rd2));
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic do_txn(input logic [6:0] a, input logic rw, input logic [7:0] d1, input logic [7:0] d2,
                          input logic ack_a, input logic ack1, input logic ack2,
                          input logic [7:0] r1, input logic [7:0] r2, input logic hold, input int rst_at);
        int   kind[$];
        logic val[$];
        logic abort, nk;
        logic prev_lvl, prev_m;
        int   ncyc, free_low, s, p, k;

        kind.push_back(K_START); val.push_back(1'b0);
        for (int i = 6; i >= 0; i--) begin kind.push_back(K_MBIT); val.push_back(a[i]); end
        kind.push_back(K_MBIT); val.push_back(rw);
        kind.push_back(K_SBIT); val.push_back(~ack_a);
        abort = ~ack_a;
        nk    = ~ack_a;
        if (!abort) begin
            for (int i = 7; i >= 0; i--) begin
                kind.push_back(rw ? K_SBIT : K_MBIT); val.push_back(rw ? r1[i] : d1[i]);
            end
            kind.push_back(rw ? K_MBIT : K_SBIT); val.push_back(rw ? 1'b0 : ~ack1);
            if (!rw && !ack1) begin abort = 1'b1; nk = 1'b1; end
        end
        if (!abort) begin
            for (int i = 7; i >= 0; i--) begin
                kind.push_back(rw ? K_SBIT : K_MBIT); val.push_back(rw ? r2[i] : d2[i]);
            end
            kind.push_back(rw ? K_MBIT : K_SBIT); val.push_back(rw ? 1'b1 : ~ack2);
            if (!rw && !ack2) nk = 1'b1;
        end
        kind.push_back(K_STOP); val.push_back(1'b1);
        ncyc = kind.size() * FD;

        bus.start   = 1'b1;
        bus.add_reg = a;
        bus.R_W     = rw;
        bus.data_1  = d1;
        bus.data_2  = d2;
        free_low = 0;
        prev_lvl = 1'b1;
        prev_m   = 1'b1;
        n_txn++;

        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (c == 0 && !hold) begin
                bus.start   = 1'b0;
                bus.add_reg = 7'($urandom);
                bus.R_W     = 1'($urandom);
                bus.data_1  = 8'($urandom);
                bus.data_2  = 8'($urandom);
            end
            s = c / FD;
            p = c % FD;
            k = kind[s];
            if (c == rst_at) begin
                sl_oe = 1'b0;
                rst = 1'b0;
                bus.start = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                exp_rd1 = 8'h00;
                exp_rd2 = 8'h00;
                exp_nack = 1'b0;
                for (int j = 0; j < 2 * FD; j++) begin
                    @(negedge clk);
                    check_val("rst_free", 32'(bus.free), 32'd1);
                    check_val("rst_scl", 32'(bus.scl), 32'd1);
                    check_val("rst_sda", 32'(sda), 32'd1);
                end
                check_done_state();
                $display("txn %0d: addr=%h rw=%0d reset in slot %0d, bus back to idle", n_txn, a, rw, s);
                return;
            end
            sl_oe  = (k == K_SBIT) && (p >= QTR);
            sl_val = val[s];
            @(negedge clk);
            if (bus.free == 1'b0) free_low++;
            check_val("scl", 32'(bus.scl), (k == K_START) ? 32'd1 : 32'(p >= HALF));
            case (k)
                K_START: check_val("sda_start", 32'(sda), 32'(p < HALF));
                K_MBIT: begin
                    if (p >= QTR) check_val("sda_bit", 32'(sda), 32'(val[s]));
                    else if (prev_m) check_val("sda_hold", 32'(sda), 32'(prev_lvl));
                end
                K_STOP: check_val("sda_stop", 32'(sda), 32'(p >= TQTR));
                default: ;
            endcase
            if (p == FD - 1) begin
                prev_m   = (k != K_SBIT);
                prev_lvl = (k == K_START) ? 1'b0 : val[s];
            end
        end

        @(posedge clk); #1;
        sl_oe = 1'b0;
        @(negedge clk);
        check_val("free_low_cycles", 32'(free_low), 32'(ncyc));
        check_val("idle_free", 32'(bus.free), 32'd1);
        check_val("idle_scl", 32'(bus.scl), 32'd1);
        check_val("idle_sda", 32'(sda), 32'd1);
        exp_nack = nk;
        if (rw && ack_a) begin
            exp_rd1 = r1;
            exp_rd2 = r2;
        end
        check_done_state();
        $display("txn %0d: addr=%h rw=%0d d1=%h d2=%h slots=%0d nack=%0d rd=%h/%h",
                 n_txn, a, rw, d1, d2, kind.size(), bus.nack, bus.rd_data_1, bus.rd_data_2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ra;
        logic       rrw, rka, rk1, rk2;
        logic [7:0] rd1, rd2, rr1, rr2;

        bus.start   = 1'b0;
        bus.add_reg = '0;
        bus.R_W     = 1'b0;
        bus.data_1  = '0;
        bus.data_2  = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_val("reset_scl", 32'(bus.scl), 32'd1);
        check_val("reset_sda", 32'(sda), 32'd1);
        check_val("reset_free", 32'(bus.free), 32'd1);
        check_done_state();

        do_txn(7'b1010110, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, -1);
        do_txn(7'b0110011, 1'b0, 8'h5A, 8'h11, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, -1);
        do_txn(7'b1010110, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC3, 8'h81, 1'b0, -1);
        do_txn(7'b1111000, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, -1);
        do_txn(7'b0000001, 1'b0, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, -1);

        for (int t = 0; t < 6; t++) begin
            ra  = 7'($urandom);
            rrw = 1'($urandom);
            rd1 = 8'($urandom);
            rd2 = 8'($urandom);
            rr1 = 8'($urandom);
            rr2 = 8'($urandom);
            rka = ($urandom_range(0, 4) != 0);
            rk1 = ($urandom_range(0, 4) != 0);
            rk2 = ($urandom_range(0, 4) != 0);
            do_txn(ra, rrw, rd1, rd2, rka, rk1, rk2, rr1, rr2, 1'b0, -1);
        end

        // start held high: back-to-back transactions separated by a single idle cycle
        do_txn(7'b1100101, 1'b0, 8'h96, 8'h69, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, -1);
        do_txn(7'b1100101, 1'b0, 8'h96, 8'h69, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, -1);
        do_txn(7'b1100101, 1'b1, 8'h96, 8'h69, 1'b1, 1'b1, 1'b1, 8'hE7, 8'h18, 1'b0, -1);

        // reset while idle with nack set, asserted together with start
        do_txn(7'b0101010, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, -1);
        rst = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.start = 1'b0;
        exp_nack = 1'b0;
        exp_rd1 = 8'h00;
        exp_rd2 = 8'h00;
        @(negedge clk);
        check_val("rst_prio_free", 32'(bus.free), 32'd1);
        check_done_state();
        @(negedge clk);
        check_val("rst_prio_free2", 32'(bus.free), 32'd1);
        check_val("rst_prio_scl", 32'(bus.scl), 32'd1);

        // load read data, then reset in the middle of a write's first data byte
        do_txn(7'b0011100, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5D, 8'hA2, 1'b0, -1);
        do_txn(7'b1010110, 1'b0, 8'hF0, 8'h0F, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 12 * FD + 2);
        do_txn(7'b1001001, 1'b0, 8'hC3, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fsm_master.md
FSM_MASTER -- requirements
Module: fsm_master

Interface
REQ-001 Parameter FREQ_DIFF, default 4: clk cycles per SCL period; SHALL be even and >=4.
REQ-002 Parameter ADDR_LEN, default 7: slave address width.
REQ-003 Parameter DATA_LEN, default 8: data byte width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; one clock, reset is synchronous and active-low.
REQ-006 start  input  1  transaction request, level-sampled in IDLE only.
REQ-007 add_reg  input  ADDR_LEN  slave address, sent MSB first.
REQ-008 R_W  input  1  direction bit: 0 = write, 1 = read.
REQ-009 data_1, data_2  input  DATA_LEN each  write bytes 1 and 2, sent MSB first.
REQ-010 scl  output  1  I2C clock, push-pull.
REQ-011 sda  inout  1  I2C data; driven 0/1 when master owns the line, released (z) in slave-owned slots.
REQ-012 free  output  1  high only in IDLE.
REQ-013 rd_data_1, rd_data_2  output  DATA_LEN each  bytes captured in a read.
REQ-014 nack  output  1  set when the slave NACKs; cleared at the next START.

Function
REQ-015 Timing: every bit slot lasts FREQ_DIFF cycles, phase counter p = 0..FREQ_DIFF-1; scl = 0 for p < FREQ_DIFF/2, else 1.
REQ-016 Master-driven sda SHALL change only at p = FREQ_DIFF/4; slave-driven sda SHALL be sampled at p = 3*FREQ_DIFF/4.
REQ-017 States: IDLE, START, ADDR, ACK_A, DATA1, ACK_1, DATA2, ACK_2, STOP.
REQ-018 IDLE: scl = 1, sda driven 1, free = 1; if start = 1 at a rising edge, latch add_reg, R_W, data_1 and data_2, clear nack, and enter START.
REQ-019 START, one slot: scl = 1 throughout; sda = 1 for p < FREQ_DIFF/2, then 0.
REQ-020 ADDR, 8 slots: add_reg MSB first, then R_W.
REQ-021 ACK_A, 1 slot: sda released; sampled value other than logic 0 -> set nack, go to STOP; else go to DATA1.
REQ-022 Write, DATA1/DATA2, 8 slots each: drive latched byte MSB first.
REQ-023 Write, ACK_1/ACK_2: sda released; a NACK on either byte -> set nack, go to STOP.
REQ-024 Read, DATA1/DATA2: sda released; shift sampled bits MSB first into rd_data_1/rd_data_2.
REQ-025 Read, ACK_1 and ACK_2: master drives 0 after byte 1 and 1 (NACK) after byte 2.
REQ-026 ACK_2 always goes to STOP.
REQ-027 STOP, one slot:
- p < FREQ_DIFF/2: scl = 0, sda = 0.
- then scl = 1, with sda = 0 until p = 3*FREQ_DIFF/4 and 1 afterwards.
- then return to IDLE.
REQ-028 Full transaction = 29 slots (29*FREQ_DIFF cycles); address-NACK abort = 11 slots.
REQ-029 Inputs change mid-transaction SHALL have no effect; only latched copies are used.
REQ-030 start held high: free SHALL be 1 for exactly one cycle in IDLE, then the next START begins.
REQ-031 rd_data_* SHALL hold their values until overwritten by the next read.

Reset
REQ-032 rst = 0 at a rising edge, in any state including mid-transfer, SHALL on that edge force:
- state IDLE, phase counter 0;
- scl = 1, sda driven 1, free = 1;
- nack = 0, rd_data_1 = rd_data_2 = 0, latched registers = 0.
REQ-033 Reset has priority over start.

Verification (FREQ_DIFF = 4)
REQ-034 Reset: rst = 0 for one cycle -> scl = 1, sda = 1, free = 1, nack = 0.
REQ-035 Write test:
- Stimulus: add_reg = 7'b1010110, R_W = 0, data_1 = 8'hA5, data_2 = 8'h3C, slave ACKs every ACK slot.
- Response: START, then sda bits 1010110 0, A, 10100101, A, 00111100, A, then STOP; free low for 116 cycles; nack = 0.
REQ-036 Address NACK, no slave (sda released high) -> STOP follows ACK_A; nack = 1; free returns after 44 cycles.
REQ-037 Read test:
- Stimulus: R_W = 1, slave returns 8'hC3 then 8'h81.
- Response: rd_data_1 = 8'hC3, rd_data_2 = 8'h81; master drives 0 in ACK_1 and 1 in ACK_2.
REQ-038 Reset mid-DATA1 -> next cycle shows IDLE values; no STOP generated.
REQ-039 start held high -> back-to-back transactions, each separated by a single free = 1 cycle.
